// File: rtl/pc_fetch_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package pc_fetch_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] RESET_VEC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] tgt;
    } redir_t;
endpackage

// File: rtl/pc_fetch_if.sv
// Instruction bus between the fetch stage (master) and instruction memory (slave).
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    logic              ibus_req;
    logic [ADDR_W-1:0] ibus_addr;
    logic              ibus_ready;
    logic [DATA_W-1:0] ibus_rdata;

    modport master (output ibus_req, ibus_addr, input ibus_ready, ibus_rdata);
    modport slave  (input ibus_req, ibus_addr, output ibus_ready, ibus_rdata);
endinterface

// File: rtl/pc_redirect.sv
// Pending-redirect register: remembers a flush or taken branch until the
// fetch stage is able to apply it, with flush taking priority over branch.
module pc_redirect
    import pc_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              br_flag,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              consume,
    output redir_t            redir
);
    logic              pend_vld;
    logic              pend_flush;
    logic [ADDR_W-1:0] pend_tgt;

    // Effective target includes this cycle's request so it can be used at once.
    always_comb begin
        redir = '0;
        if (flush) begin
            redir.vld = 1'b1;
            redir.tgt = flush_pc;
        end else if (pend_vld && pend_flush) begin
            redir.vld = 1'b1;
            redir.tgt = pend_tgt;
        end else if (br_flag) begin
            redir.vld = 1'b1;
            redir.tgt = br_addr;
        end else if (pend_vld) begin
            redir.vld = 1'b1;
            redir.tgt = pend_tgt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_vld   <= 1'b0;
            pend_flush <= 1'b0;
            pend_tgt   <= '0;
        end else if (consume) begin
            pend_vld   <= 1'b0;
            pend_flush <= 1'b0;
        end else if (flush) begin
            pend_vld   <= 1'b1;
            pend_flush <= 1'b1;
            pend_tgt   <= flush_pc;
        end else if (br_flag && !(pend_vld && pend_flush)) begin
            pend_vld   <= 1'b1;
            pend_flush <= 1'b0;
            pend_tgt   <= br_addr;
        end
    end
endmodule

// File: rtl/pc_fetch.sv
// Instruction-fetch stage: drives the instruction bus, buffers a word across
// IF/ID stalls, and applies branch/flush redirects without abandoning a bus cycle.
module pc_fetch
    import pc_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              br_flag,
    input  logic [ADDR_W-1:0] br_addr,
    pc_fetch_if.master        ibus,
    output logic [ADDR_W-1:0] if_pc,
    output logic [ADDR_W-1:0] if_pcp4,
    output logic [DATA_W-1:0] if_inst,
    output logic              if_stallreq
);
    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] buf_inst;
    logic              req_q;
    logic              if_valid;
    logic              consume;
    logic [ADDR_W-1:0] adv_pc;
    redir_t            redir;

    pc_redirect u_redirect (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .flush_pc (flush_pc),
        .br_flag  (br_flag),
        .br_addr  (br_addr),
        .consume  (consume),
        .redir    (redir)
    );

    // A pending redirect is applied exactly when the pc advances.
    always_comb begin
        consume = 1'b0;
        case (state)
            BOOT:  consume = 1'b1;
            FETCH: consume = ibus.ibus_ready && (flush || !stall);
            HOLD:  consume = flush || !stall;
            DRAIN: consume = ibus.ibus_ready;
        endcase
    end

    assign adv_pc         = redir.vld ? redir.tgt : pc + 32'd4;
    assign ibus.ibus_req  = req_q;
    assign ibus.ibus_addr = pc;
    assign if_stallreq    = (state != HOLD) && !if_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= BOOT;
            pc       <= RESET_VEC;
            req_q    <= 1'b0;
            buf_inst <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_pcp4  <= '0;
            if_inst  <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                    req_q <= 1'b1;
                    pc    <= redir.vld ? redir.tgt : RESET_VEC;
                end
                FETCH: begin
                    if (flush) begin
                        if_valid <= 1'b0;
                        if_pc    <= '0;
                        if_pcp4  <= '0;
                        if_inst  <= '0;
                        // Outstanding request must complete before redirecting.
                        if (ibus.ibus_ready) pc <= adv_pc;
                        else                 state <= DRAIN;
                    end else if (ibus.ibus_ready && !stall) begin
                        if_valid <= 1'b1;
                        if_pc    <= pc;
                        if_pcp4  <= pc + 32'd4;
                        if_inst  <= ibus.ibus_rdata;
                        pc       <= adv_pc;
                    end else if (ibus.ibus_ready) begin
                        buf_inst <= ibus.ibus_rdata;
                        req_q    <= 1'b0;
                        state    <= HOLD;
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                        if_inst  <= '0;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        if_valid <= 1'b0;
                        if_pc    <= '0;
                        if_pcp4  <= '0;
                        if_inst  <= '0;
                        pc       <= adv_pc;
                        req_q    <= 1'b1;
                        state    <= FETCH;
                    end else if (!stall) begin
                        if_valid <= 1'b1;
                        if_pc    <= pc;
                        if_pcp4  <= pc + 32'd4;
                        if_inst  <= buf_inst;
                        pc       <= adv_pc;
                        req_q    <= 1'b1;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (flush) begin
                        if_valid <= 1'b0;
                        if_pc    <= '0;
                        if_pcp4  <= '0;
                        if_inst  <= '0;
                    end
                    if (ibus.ibus_ready) begin
                        pc    <= adv_pc;
                        state <= FETCH;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: boot sequence, delay slot, wrap, stall buffering,
// flush drain, flush/branch priority and reset mid-transaction.
module tb_pc_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        br_flag = 1'b0;
    logic [31:0] br_addr = '0;
    logic        rdy_en = 1'b1;
    logic        rdy_force = 1'b0;
    logic [31:0] if_pc, if_pcp4, if_inst;
    logic        if_stallreq;
    int          n_chk = 0;
    int          n_err = 0;

    pc_fetch_if ifc ();

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: word is a fixed function of the address, ready on request.
    assign ifc.ibus_ready = (rdy_en & ifc.ibus_req) | rdy_force;
    assign ifc.ibus_rdata = w(ifc.ibus_addr);

    pc_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .flush       (flush),
        .flush_pc    (flush_pc),
        .br_flag     (br_flag),
        .br_addr     (br_addr),
        .ibus        (ifc),
        .if_pc       (if_pc),
        .if_pcp4     (if_pcp4),
        .if_inst     (if_inst),
        .if_stallreq (if_stallreq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req",      {31'b0, ifc.ibus_req}, 32'd0);
        chk("rst_addr",     ifc.ibus_addr, 32'hBFC0_0000);
        chk("rst_if_pc",    if_pc, 32'd0);
        chk("rst_if_pcp4",  if_pcp4, 32'd0);
        chk("rst_if_inst",  if_inst, 32'd0);
        chk("rst_stallreq", {31'b0, if_stallreq}, 32'd1);

        rst = 1'b0;
        tick();
        chk("boot_req",  {31'b0, ifc.ibus_req}, 32'd1);
        chk("boot_addr", ifc.ibus_addr, 32'hBFC0_0000);
        tick();
        chk("f0_addr",     ifc.ibus_addr, 32'hBFC0_0004);
        chk("f0_inst",     if_inst, w(32'hBFC0_0000));
        chk("f0_pc",       if_pc, 32'hBFC0_0000);
        chk("f0_pcp4",     if_pcp4, 32'hBFC0_0004);
        chk("f0_stallreq", {31'b0, if_stallreq}, 32'd0);
        tick();
        chk("f1_addr", ifc.ibus_addr, 32'hBFC0_0008);
        chk("f1_pc",   if_pc, 32'hBFC0_0004);

        // Branch while 0xBFC00008 is being fetched: it is the delay slot.
        br_flag = 1'b1; br_addr = 32'h8000_0100;
        tick();
        br_flag = 1'b0;
        chk("ds_pc",   if_pc, 32'hBFC0_0008);
        chk("ds_inst", if_inst, w(32'hBFC0_0008));
        chk("br_addr", ifc.ibus_addr, 32'h8000_0100);

        // Branch to the top of the address space, then wrap.
        br_flag = 1'b1; br_addr = 32'hFFFF_FFFC;
        tick();
        br_flag = 1'b0;
        chk("top_addr", ifc.ibus_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_addr", ifc.ibus_addr, 32'h0000_0000);
        chk("wrap_pc",   if_pc, 32'hFFFF_FFFC);
        chk("wrap_pcp4", if_pcp4, 32'h0000_0000);

        // Stall for 4 cycles; the word returns during the stall.
        stall = 1'b1; rdy_en = 1'b0;
        tick();
        chk("st_hold_inst", if_inst, w(32'hFFFF_FFFC));
        chk("st_hold_addr", ifc.ibus_addr, 32'h0000_0000);
        rdy_en = 1'b1;
        tick();
        chk("st_buf_req",  {31'b0, ifc.ibus_req}, 32'd0);
        chk("st_buf_inst", if_inst, w(32'hFFFF_FFFC));
        chk("st_buf_sreq", {31'b0, if_stallreq}, 32'd0);
        tick();
        tick();
        chk("st_hold_req", {31'b0, ifc.ibus_req}, 32'd0);
        chk("st_hold_pc",  if_pc, 32'hFFFF_FFFC);
        stall = 1'b0;
        tick();
        chk("st_rel_inst", if_inst, w(32'h0000_0000));
        chk("st_rel_pc",   if_pc, 32'h0000_0000);
        chk("st_rel_req",  {31'b0, ifc.ibus_req}, 32'd1);
        chk("st_rel_addr", ifc.ibus_addr, 32'h0000_0004);
        rdy_en = 1'b0;
        tick();
        chk("st_once_inst", if_inst, 32'd0);
        chk("st_once_sreq", {31'b0, if_stallreq}, 32'd1);

        // Flush with the fetch of 0x4 outstanding and ready delayed.
        flush = 1'b1; flush_pc = 32'hBFC0_0380;
        tick();
        flush = 1'b0;
        chk("fl_addr_hold0", ifc.ibus_addr, 32'h0000_0004);
        chk("fl_req",        {31'b0, ifc.ibus_req}, 32'd1);
        chk("fl_if_pc",      if_pc, 32'd0);
        chk("fl_sreq",       {31'b0, if_stallreq}, 32'd1);
        tick();
        chk("fl_addr_hold1", ifc.ibus_addr, 32'h0000_0004);
        rdy_en = 1'b1;
        tick();
        chk("fl_redir_addr", ifc.ibus_addr, 32'hBFC0_0380);
        chk("fl_stale_inst", if_inst, 32'd0);
        tick();
        chk("fl_new_inst", if_inst, w(32'hBFC0_0380));
        chk("fl_new_pc",   if_pc, 32'hBFC0_0380);

        // Flush and branch together while ready returns: flush wins, no drain.
        flush = 1'b1; flush_pc = 32'hBFC0_0200;
        br_flag = 1'b1; br_addr = 32'h8000_0400;
        tick();
        flush = 1'b0; br_flag = 1'b0;
        chk("fb_addr", ifc.ibus_addr, 32'hBFC0_0200);
        chk("fb_inst", if_inst, 32'd0);
        chk("fb_pc",   if_pc, 32'd0);
        tick();
        chk("fb_next_addr", ifc.ibus_addr, 32'hBFC0_0204);
        chk("fb_next_pc",   if_pc, 32'hBFC0_0200);

        // Reset in the middle of an outstanding fetch, with a late ready.
        rdy_en = 1'b0;
        tick();
        chk("mr_req_before", {31'b0, ifc.ibus_req}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mr_req_drop", {31'b0, ifc.ibus_req}, 32'd0);
        #1;
        rst = 1'b0; rdy_force = 1'b1;
        tick();
        rdy_force = 1'b0; rdy_en = 1'b1;
        chk("mr_boot_addr", ifc.ibus_addr, 32'hBFC0_0000);
        chk("mr_boot_inst", if_inst, 32'd0);
        chk("mr_boot_req",  {31'b0, ifc.ibus_req}, 32'd1);
        tick();
        chk("mr_first_inst", if_inst, w(32'hBFC0_0000));
        chk("mr_first_pc",   if_pc, 32'hBFC0_0000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have port clk  in  1  single clock for all state; every register updates on its rising edge.
REQ-002 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port stall  in  1  IF/ID stall from pipeline control; hold current IF outputs.
REQ-004 SHALL have port flush  in  1  exception/eret flush from pipeline control.
REQ-005 SHALL have port flush_pc  in  32  redirect target, qualified by flush.
REQ-006 SHALL have port br_flag  in  1  branch taken, resolved in ID.
REQ-007 SHALL have port br_addr  in  32  branch target, qualified by br_flag.
REQ-008 SHALL have port ibus_req  out  1  instruction fetch request.
REQ-009 SHALL have port ibus_addr  out  32  fetch address; stable while ibus_req=1 and no ibus_ready.
REQ-010 SHALL have port ibus_ready  in  1  one-cycle pulse; ibus_rdata valid in the same cycle.
REQ-011 SHALL have port ibus_rdata  in  32  fetched instruction word.
REQ-012 SHALL have port if_pc  out  32  PC of the instruction presented to IF/ID.
REQ-013 SHALL have port if_pcp4  out  32  if_pc+4.
REQ-014 SHALL have port if_inst  out  32  instruction word; 0 (nop) when none is valid.
REQ-015 SHALL have port if_stallreq  out  1  IF not ready; asks pipeline control to stall.

Function
REQ-016 SHALL implement FSM states BOOT, FETCH, HOLD, DRAIN.
REQ-017 BOOT: ibus_req=0 for exactly one cycle after reset, then go to FETCH with pc=reset vector.
REQ-018 FETCH: ibus_req=1, ibus_addr=pc; on ibus_ready with stall=0 present the word and advance pc; with stall=1 buffer the word and go to HOLD.
REQ-019 HOLD: ibus_req=0; present the buffered word; when stall=0, advance pc and go to FETCH.
REQ-020 DRAIN: ibus_req=1 on the old address; on ibus_ready discard the word and go to FETCH at the pending redirect target.
REQ-021 Presentation SHALL be registered: a word accepted on ibus_ready appears on if_inst the next cycle.
REQ-022 if_stallreq SHALL be 1 in BOOT, FETCH and DRAIN while no valid word is presented, and 0 otherwise.
REQ-023 The pc advance SHALL be redirect-target if pending, else pc+4; arithmetic is 32-bit modulo, so 0xFFFFFFFC+4 = 0x00000000 with no fault.
REQ-024 Redirect priority SHALL be flush over br_flag; a redirect is latched into a pending register (valid+target) in the cycle it is seen, and a newer flush overwrites a pending branch.
REQ-025 br_flag SHALL preserve the delay slot: the word in IF when br_flag rises is still delivered, and the following fetch uses br_addr.
REQ-026 flush SHALL discard the presented word (if_inst=0, if_pc=0 next cycle) and any buffered word; with a fetch in flight go to DRAIN, otherwise go to FETCH at flush_pc next cycle.
REQ-027 A bus transaction SHALL never be abandoned: ibus_req and ibus_addr stay constant from assertion until ibus_ready.
REQ-028 Simultaneous flush and ibus_ready in FETCH SHALL discard the word and start FETCH at flush_pc next cycle, with no DRAIN.
REQ-029 While stall=1 outside HOLD and DRAIN, if_pc, if_pcp4 and if_inst SHALL hold their values.

Reset
REQ-030 On rst: state=BOOT, pc=0xBFC00000, pending redirect cleared, buffer invalid, if_pc=if_pcp4=if_inst=0, ibus_req=0, if_stallreq=1.
REQ-031 rst asserted mid-transaction SHALL drop ibus_req immediately; a late ibus_ready after reset is ignored while in BOOT.

Structure
REQ-032 The reset vector 0xBFC00000, the FSM state encoding and the 32-bit address/data bus widths SHALL live in the shared defines file.
REQ-033 One sub-module, pc_redirect, SHALL hold the pending-redirect register and priority logic; everything else stays in pc_fetch.

Verification
REQ-034 Reset release with ibus_ready returning every cycle -> one idle cycle, then addresses 0xBFC00000, 0xBFC00004, 0xBFC00008 in order.
REQ-035 br_flag=1 with br_addr=0x80000100 while 0xBFC00008 is in IF -> 0xBFC00008 (delay slot) is delivered, next ibus_addr is 0x80000100.
REQ-036 flush=1 with flush_pc=0xBFC00380 while a fetch is outstanding with ibus_ready delayed 3 cycles -> address held, stale word discarded, next ibus_addr is 0xBFC00380.
REQ-037 stall=1 held 4 cycles while ibus_ready arrives -> word buffered, ibus_req=0, if_inst held; on release it is delivered exactly once.
REQ-038 flush and br_flag asserted in the same cycle -> fetch resumes at flush_pc and br_addr is never issued.
REQ-039 pc=0xFFFFFFFC -> next ibus_addr is 0x00000000 and if_pcp4 is 0x00000000.
